// File: rtl/cpu_mem_if.sv
// cpu_mem_if: CPU instruction/data memory bus between the custom CPU
// (master) and its memory responder (slave).
//
// Signals (names kept from the original flat port list):
//   Fetch request : PC[31:0], Inst_Req_Valid  (M->S), Inst_Req_Ready (S->M)
//   Fetch response: Instruction[31:0], Inst_Valid (S->M), Inst_Ready (M->S)
//   Data request  : Address[31:0], MemWrite, Write_data[31:0],
//                   Write_strb[3:0], MemRead (M->S), Mem_Req_Ready (S->M)
//   Load response : Read_data[31:0], Read_data_Valid (S->M),
//                   Read_data_Ready (M->S)
interface cpu_mem_if;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;

    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    modport master (
        output PC, Inst_Req_Valid, Inst_Ready,
        output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        input  Inst_Req_Ready, Instruction, Inst_Valid,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ready,
        input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        output Inst_Req_Ready, Instruction, Inst_Valid,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory target answering the CPU's instruction-fetch
// and load/store channels from one word-addressed array with byte strobes.
// One transaction is outstanding at a time; reads respond LATENCY+1 cycles
// after acceptance, data requests win over fetches on a same-cycle conflict.
//
// Parameters:
//   ADDR_WIDTH - word-address bits (array holds 2**ADDR_WIDTH 32-bit words)
//   LATENCY    - extra wait cycles before a read response (0..15)
//
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - cpu_mem_if.slave (fetch, load/store request and response channels)
//
// Optional build macro MEM_RAND_DELAY_EN: adds a 16-bit LFSR that jitters
// read latency by 0..3 cycles and inserts a one-cycle BUSY after some stores.
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic     clk,
    input  logic     rst,
    cpu_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        BUSY
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] mem [DEPTH];

    logic [4:0]            cnt;
    logic [4:0]            cnt_load;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  src_inst;
    logic [ADDR_WIDTH-1:0] data_idx;
    logic [ADDR_WIDTH-1:0] inst_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  data_req;
    logic                  store_hs;
    logic                  load_hs;
    logic                  fetch_hs;
    logic                  read_hs;
    logic                  resp_src;
    logic                  resp_entry;
    logic                  resp_done;
    logic                  store_busy;
    logic                  unused_addr_bits;

    // Word index ignores byte offset and everything above the array size,
    // so addresses alias modulo the array.
    assign data_idx = bus.Address[ADDR_WIDTH+1:2];
    assign inst_idx = bus.PC[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.PC, bus.Address};

    assign data_req = bus.MemRead | bus.MemWrite;

    // Handshakes mirror the ready equations below: data has priority,
    // and a store with MemRead also high is a store.
    assign store_hs = (state == IDLE) & bus.MemWrite;
    assign load_hs  = (state == IDLE) & bus.MemRead & ~bus.MemWrite;
    assign fetch_hs = (state == IDLE) & ~data_req & bus.Inst_Req_Valid;
    assign read_hs  = load_hs | fetch_hs;

    // With zero wait the response is entered straight from IDLE, so the
    // index and source come from the live request rather than the latches.
    assign rd_idx     = (state == IDLE) ? (load_hs ? data_idx : inst_idx) : idx_q;
    assign resp_src   = (state == IDLE) ? fetch_hs : src_inst;
    assign resp_entry = (state_next == RESP) & (state != RESP);
    assign resp_done  = (state == RESP) & (src_inst ? bus.Inst_Ready : bus.Read_data_Ready);

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cnt_load   = 5'(LATENCY) + {3'b000, lfsr[1:0]};
    assign store_busy = lfsr[0];
`else
    assign cnt_load   = 5'(LATENCY);
    assign store_busy = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (store_hs) begin
                    state_next = store_busy ? BUSY : IDLE;
                end else if (read_hs) begin
                    state_next = (cnt_load == 5'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 5'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request readiness depends only on state and the request inputs.
    always_comb begin
        bus.Mem_Req_Ready  = 1'b0;
        bus.Inst_Req_Ready = 1'b0;
        if (state == IDLE) begin
            bus.Mem_Req_Ready  = 1'b1;
            bus.Inst_Req_Ready = ~data_req;
        end
    end

    // Read tracking and response registers. The array is sampled when the
    // response is entered, so a preceding store to the same word is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt                 <= '0;
            idx_q               <= '0;
            src_inst            <= 1'b0;
            bus.Inst_Valid      <= 1'b0;
            bus.Read_data_Valid <= 1'b0;
            bus.Instruction     <= '0;
            bus.Read_data       <= '0;
        end else begin
            if (read_hs) begin
                idx_q    <= rd_idx;
                src_inst <= fetch_hs;
                cnt      <= cnt_load;
            end else if (state == WAIT) begin
                cnt <= cnt - 5'd1;
            end

            if (resp_entry) begin
                if (resp_src) begin
                    bus.Instruction     <= mem[rd_idx];
                    bus.Inst_Valid      <= 1'b1;
                    bus.Read_data       <= '0;
                    bus.Read_data_Valid <= 1'b0;
                end else begin
                    bus.Read_data       <= mem[rd_idx];
                    bus.Read_data_Valid <= 1'b1;
                    bus.Instruction     <= '0;
                    bus.Inst_Valid      <= 1'b0;
                end
            end else if (resp_done) begin
                bus.Inst_Valid      <= 1'b0;
                bus.Read_data_Valid <= 1'b0;
            end
        end
    end

    // Storage array, not reset; byte lanes written on a store handshake.
    always_ff @(posedge clk) begin
        if (store_hs && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.Write_strb[i]) begin
                    mem[data_idx][8*i +: 8] <= bus.Write_data[8*i +: 8];
                end
            end
        end
    end
endmodule
